// File: rtl/nn_layer_sequencer.sv
// Sequential two-layer fixed-point inference engine: one shared MAC walks every
// neuron, fetching bias/weights from a synchronous ROM and hidden sums through a tanh LUT.
module nn_layer_sequencer #(
  parameter int unsigned N_IN  = 7,
  parameter int unsigned N_HID = 128,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned DW    = 9,
  parameter int unsigned FRAC  = 4,
  parameter int unsigned ACC_W = 26,
  parameter int unsigned AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic          op_sel,
  output logic [6:0]    op_addr,
  input  logic [DW-1:0] op_data,
  output logic          act_req,
  output logic [DW-1:0] act_in,
  input  logic          act_ack,
  input  logic [DW-1:0] act_out,
  output logic          h_we,
  output logic [6:0]    h_addr,
  output logic [DW-1:0] h_wdata,
  output logic          y_valid,
  output logic [1:0]    y_idx,
  output logic [DW-1:0] y_data
);

  localparam int unsigned KW       = 8;
  localparam int unsigned NW       = 7;
  localparam int unsigned PW       = 2 * DW;
  localparam int unsigned OUT_BASE = N_HID * (N_IN + 1);
  localparam logic signed [ACC_W:0] S_MAX = (ACC_W + 1)'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W:0] S_MIN = ~S_MAX;
  localparam logic signed [ACC_W:0] HALF  = (ACC_W + 1)'(2 ** (FRAC - 1));

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_SAT, S_ACT} state_t;

  state_t                   state, state_n;
  logic                     layer, layer_n;
  logic [NW-1:0]            neuron, neuron_n;
  logic [KW-1:0]            k, k_n, k_last;
  logic signed [ACC_W-1:0]  acc, acc_n, bias_ext, prod_ext;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W:0]    rnd, shf;
  logic [DW-1:0]            s;
  logic [AW-1:0]            base_n;

  logic          busy_n, done_n, op_sel_n, act_req_n, y_valid_n;
  logic [AW-1:0] w_addr_n;
  logic [6:0]    op_addr_n;
  logic [DW-1:0] act_in_n, y_data_n;
  logic [1:0]    y_idx_n;

  // MAC operands and round-half-up saturation of the finished sum
  always_comb begin
    prod     = $signed(w_data) * $signed(op_data);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'($signed(w_data)) <<< FRAC;
    rnd      = {acc[ACC_W-1], acc} + HALF;
    shf      = rnd >>> FRAC;
    if (shf > S_MAX)      s = S_MAX[DW-1:0];
    else if (shf < S_MIN) s = S_MIN[DW-1:0];
    else                  s = shf[DW-1:0];
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_n  = state;
    layer_n  = layer;
    neuron_n = neuron;
    k_n      = k;
    acc_n    = acc;
    k_last   = layer ? KW'(N_HID) : KW'(N_IN);

    case (state)
      S_IDLE: begin
        if (start && !done) begin
          state_n  = S_BIAS;
          layer_n  = 1'b0;
          neuron_n = '0;
        end
      end
      S_BIAS: begin
        state_n = S_MAC;
        k_n     = '0;
      end
      S_MAC: begin
        acc_n = (k == '0) ? bias_ext : acc + prod_ext;
        if (k == k_last) state_n = S_SAT;
        else             k_n     = k + KW'(1);
      end
      S_SAT: begin
        if (!layer) begin
          state_n = S_ACT;
        end else if (neuron == NW'(N_OUT - 1)) begin
          state_n = S_IDLE;
        end else begin
          state_n  = S_BIAS;
          neuron_n = neuron + NW'(1);
        end
      end
      S_ACT: begin
        if (act_ack) begin
          state_n = S_BIAS;
          if (neuron == NW'(N_HID - 1)) begin
            layer_n  = 1'b1;
            neuron_n = '0;
          end else begin
            neuron_n = neuron + NW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    base_n = layer_n ? AW'(OUT_BASE) + AW'(neuron_n) * AW'(N_HID + 1)
                     : AW'(neuron_n) * AW'(N_IN + 1);

    done_n    = (state == S_SAT) && layer && (neuron == NW'(N_OUT - 1));
    busy_n    = (state_n != S_IDLE) || done_n;
    y_valid_n = (state == S_SAT) && layer;
    y_idx_n   = y_valid_n ? 2'(neuron) : ((state_n == S_IDLE) ? 2'd0 : y_idx);
    y_data_n  = y_valid_n ? s : ((state_n == S_IDLE) ? '0 : y_data);

    w_addr_n  = '0;
    op_sel_n  = 1'b0;
    op_addr_n = '0;
    if (state_n == S_BIAS) begin
      w_addr_n = base_n;
    end else if (state_n == S_MAC) begin
      w_addr_n = base_n + AW'(k_n) + AW'(1);
      if (k_n != '0) begin
        op_sel_n  = layer_n;
        op_addr_n = NW'(k_n - KW'(1));
      end
    end

    // act_in captures the clamped sum on SAT->ACT and holds for the whole handshake
    act_req_n = (state_n == S_ACT);
    if (state_n != S_ACT)    act_in_n = '0;
    else if (state == S_SAT) act_in_n = s;
    else                     act_in_n = act_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      layer   <= 1'b0;
      neuron  <= '0;
      k       <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_addr  <= '0;
      op_sel  <= 1'b0;
      op_addr <= '0;
      act_req <= 1'b0;
      act_in  <= '0;
      y_valid <= 1'b0;
      y_idx   <= '0;
      y_data  <= '0;
    end else begin
      state   <= state_n;
      layer   <= layer_n;
      neuron  <= neuron_n;
      k       <= k_n;
      acc     <= acc_n;
      busy    <= busy_n;
      done    <= done_n;
      w_addr  <= w_addr_n;
      op_sel  <= op_sel_n;
      op_addr <= op_addr_n;
      act_req <= act_req_n;
      act_in  <= act_in_n;
      y_valid <= y_valid_n;
      y_idx   <= y_idx_n;
      y_data  <= y_data_n;
    end
  end

  // Hidden write lands in the ack cycle itself; reset suppresses it
  assign h_we    = (state == S_ACT) && act_ack && !rst;
  assign h_addr  = h_we ? neuron : '0;
  assign h_wdata = h_we ? act_out : '0;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: ROM, operand buffers and tanh responder are
// modelled here; expected hidden writes, outputs and done cycles are queued per run.
module tb_nn_layer_sequencer;

  typedef struct { int addr; int pre; int post; int len; } hexp_t;
  typedef struct { int idx; int val; } yexp_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, op_sel, act_req, act_ack, h_we, y_valid;
  logic [10:0] w_addr;
  logic [8:0]  w_data, op_data, act_in, act_out, h_wdata, y_data;
  logic [6:0]  op_addr, h_addr;
  logic [1:0]  y_idx;

  logic [8:0] rom [0:2047];
  logic [8:0] xin [0:127];
  logic [8:0] hid [0:127];

  hexp_t hq[$];
  yexp_t yq[$];
  int    dq[$];

  int n_cmp = 0, n_bad = 0;
  int cnt = 0, t0 = 0, done_cnt = 0;
  int req_len = 0, hold = 0;
  int wcnt = 0, ack_idx = 0, slow_n = -1;
  bit stray_en = 1'b0;

  nn_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .w_data(w_data), .op_sel(op_sel), .op_addr(op_addr),
    .op_data(op_data), .act_req(act_req), .act_in(act_in), .act_ack(act_ack),
    .act_out(act_out), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  always @(posedge clk) w_data <= rom[w_addr];
  always @(posedge clk) if (h_we) hid[h_addr] <= h_wdata;
  assign op_data = op_sel ? hid[op_addr] : xin[op_addr];

  function automatic int sx(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Identity tanh; one chosen neuron waits 3 cycles; optional stray acks while not requesting
  always @(posedge clk) begin
    #1;
    if (act_req) begin
      if (wcnt >= ((ack_idx == slow_n) ? 3 : 0)) begin
        act_ack = 1'b1;
        act_out = act_in;
        ack_idx++;
      end else begin
        act_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt    = 0;
      act_ack = stray_en && busy && (op_addr == 7'd3);
      act_out = 9'h055;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, an output or done
  always @(negedge clk) begin
    hexp_t he;
    yexp_t ye;
    int    de;
    if (act_req) begin
      if (req_len > 0) chk("act_in_hold", sx(act_in), hold);
      hold = sx(act_in);
      req_len++;
    end
    if (h_we) begin
      if (hq.size() == 0) chk("h_we_unexpected", 1, 0);
      else begin
        he = hq.pop_front();
        chk("h_addr", int'(h_addr), he.addr);
        chk("act_in_pre", sx(act_in), he.pre);
        chk("h_wdata", sx(h_wdata), he.post);
        chk("act_req_len", req_len, he.len);
      end
    end
    if (!act_req) req_len = 0;
    if (y_valid) begin
      if (yq.size() == 0) chk("y_valid_unexpected", 1, 0);
      else begin
        ye = yq.pop_front();
        chk("y_idx", int'(y_idx), ye.idx);
        chk("y_data", sx(y_data), ye.val);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        de = dq.pop_front();
        chk("done_cycle", cnt - t0, de);
        chk("done_with_y_valid", int'(y_valid), 1);
        chk("busy_in_done", int'(busy), 1);
      end
      done_cnt++;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_act_req"}, int'(act_req), 0);
    chk({tag, "_h_we"}, int'(h_we), 0);
    chk({tag, "_y_valid"}, int'(y_valid), 0);
    chk({tag, "_y_idx"}, int'(y_idx), 0);
    chk({tag, "_y_data"}, int'(y_data), 0);
    chk({tag, "_w_addr"}, int'(w_addr), 0);
    chk({tag, "_op_addr"}, int'(op_addr), 0);
    chk({tag, "_op_sel"}, int'(op_sel), 0);
    chk({tag, "_act_in"}, int'(act_in), 0);
    chk({tag, "_h_addr"}, int'(h_addr), 0);
    chk({tag, "_h_wdata"}, int'(h_wdata), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    for (int i = 0; i < 128; i++) xin[i] = '0;
    ack_idx = 0;
  endtask

  // Hidden: bias 1.0, weights 0 -> 16. Output: 128 * 16 * 1 = 2048 -> 128 (8.0 in Q4.4)
  task automatic cfg_identity(input int slow);
    clear_mem();
    for (int i = 0; i < 7; i++) xin[i] = 9'(i * 37 + 3);
    for (int n = 0; n < 128; n++) begin
      rom[n * 8] = 9'h010;
      hq.push_back('{n, 16, 16, (n == slow) ? 4 : 1});
    end
    for (int m = 0; m < 3; m++) begin
      for (int j = 1; j <= 128; j++) rom[1024 + m * 129 + j] = 9'h001;
      yq.push_back('{m, 128});
    end
  endtask

  // Every word and input set to v; hidden clamps to hpre, outputs clamp to +255
  task automatic cfg_fill(input logic [8:0] v, input int hpre);
    clear_mem();
    for (int i = 0; i < 1411; i++) rom[i] = v;
    for (int i = 0; i < 7; i++) xin[i] = 9'h0FF;
    for (int n = 0; n < 128; n++) hq.push_back('{n, hpre, hpre, 1});
    for (int m = 0; m < 3; m++) yq.push_back('{m, 255});
  endtask

  // Single non-zero weight per neuron: +8 -> 1, +7 -> 0, -8 -> 0, -9 -> -1.
  // Outputs: bias m plus 32 ones -> (16m + 32 + 8) >> 4 = m + 2
  task automatic cfg_round();
    int pre [4];
    pre = '{1, 0, 0, -1};
    clear_mem();
    xin[0] = 9'd8; xin[1] = 9'd7; xin[2] = 9'd8; xin[3] = 9'd9;
    for (int i = 4; i < 7; i++) xin[i] = 9'd5;
    for (int n = 0; n < 128; n++) begin
      rom[n * 8 + 1 + (n % 4)] = ((n % 4) < 2) ? 9'h001 : 9'h1FF;
      hq.push_back('{n, pre[n % 4], pre[n % 4], 1});
    end
    for (int m = 0; m < 3; m++) begin
      rom[1024 + m * 129] = 9'(m);
      for (int j = 0; j < 128; j += 4) rom[1024 + m * 129 + 1 + j] = 9'h001;
      yq.push_back('{m, m + 2});
    end
  endtask

  task automatic run(input int exp_done, input bit pulses);
    int seen;
    bit got;
    dq.push_back(exp_done);
    seen = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; t0 = cnt - 1;
    chk("busy_cycle1", int'(busy), 1);
    got = 1'b0;
    for (int c = 0; c < 2500 && !got; c++) begin
      @(negedge clk);
      if (pulses) start = ((cnt - t0) == 29) || ((cnt - t0) == 67);
      if (done_cnt != seen) got = 1'b1;
    end
    start = 1'b0;
    chk("run_finished", int'(got), 1);
    repeat (3) @(negedge clk);
    chk("idle_after_run", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; act_ack = 1'b0; act_out = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("por");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    cfg_identity(-1);
    run(1802, 1'b0);

    slow_n = 5; stray_en = 1'b1;
    cfg_identity(5);
    run(1805, 1'b1);
    slow_n = -1; stray_en = 1'b0;

    cfg_fill(9'h0FF, 255);
    run(1802, 1'b0);
    cfg_fill(9'h100, -256);
    run(1802, 1'b0);
    cfg_round();
    run(1802, 1'b0);

    // Reset in the middle of neuron 1's MAC, then a clean run
    cfg_identity(-1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; t0 = cnt - 1;
    while ((cnt - t0) < 18) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    hq.delete(); yq.delete(); dq.delete();
    ack_idx = 0;
    @(negedge clk);
    check_zero("post_rst");
    cfg_identity(-1);
    run(1802, 1'b0);

    chk("hq_drained", hq.size(), 0);
    chk("yq_drained", yq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
